// File: rtl/vga_timing_gen.sv
// Programmable VGA timing generator: pixel-clock enable divider, sync/blank decode,
// pixel coordinates, frame counter and a stop-at-frame-boundary run control.
module vga_timing_gen #(
   parameter int CLK_DIV  = 2,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int PIPE_DLY = 0,
   parameter int CW       = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   output logic          pix_en,
   output logic          h_sync,
   output logic          v_sync,
   output logic          active,
   output logic          line_start,
   output logic          frame_start,
   output logic [CW-1:0] pix_x,
   output logic [CW-1:0] pix_y,
   output logic [31:0]   frame_count,
   output logic          running
);

   localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
   localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
   localparam int H_ACT0  = H_SYNC + H_BP;
   localparam int H_ACT1  = H_ACT0 + H_ACTIVE;
   localparam int V_ACT0  = V_SYNC + V_BP;
   localparam int V_ACT1  = V_ACT0 + V_ACTIVE;
   localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);

   typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

   typedef struct packed {
      logic          h_sync;
      logic          v_sync;
      logic          active;
      logic          line_start;
      logic          frame_start;
      logic [CW-1:0] pix_x;
      logic [CW-1:0] pix_y;
   } video_t;

   localparam video_t VIDEO_RST = '{
      h_sync: ~HS_POL, v_sync: ~VS_POL, active: 1'b0, line_start: 1'b0,
      frame_start: 1'b0, pix_x: '0, pix_y: '0
   };

   state_t         state;
   logic [DW-1:0]  div_cnt;
   logic [HW-1:0]  hc;
   logic [VW-1:0]  vc;
   video_t         pipe [0:PIPE_DLY];
   video_t         dec;
   logic           h_act;
   logic           v_act;
   logic           h_last;
   logic           v_last;
   logic           frame_wrap;

   always_comb begin
      h_act           = (hc >= HW'(H_ACT0)) && (hc < HW'(H_ACT1));
      v_act           = (vc >= VW'(V_ACT0)) && (vc < VW'(V_ACT1));
      dec             = VIDEO_RST;
      dec.h_sync      = (hc < HW'(H_SYNC)) ? HS_POL : ~HS_POL;
      dec.v_sync      = (vc < VW'(V_SYNC)) ? VS_POL : ~VS_POL;
      dec.active      = h_act && v_act;
      if (h_act && v_act) begin
         dec.pix_x       = CW'(hc - HW'(H_ACT0));
         dec.pix_y       = CW'(vc - VW'(V_ACT0));
         dec.line_start  = (hc == HW'(H_ACT0));
         dec.frame_start = (hc == HW'(H_ACT0)) && (vc == VW'(V_ACT0));
      end
   end

   assign h_last     = (hc == HW'(H_TOTAL - 1));
   assign v_last     = (vc == VW'(V_TOTAL - 1));
   assign frame_wrap = pix_en && h_last && v_last;

   // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= IDLE;
         div_cnt     <= '0;
         pix_en      <= 1'b0;
         hc          <= '0;
         vc          <= '0;
         frame_count <= '0;
         // NOTE: the delay line is reset too, so no stale pixels emerge after reset release.
         for (int i = 0; i <= PIPE_DLY; i++) pipe[i] <= VIDEO_RST;
      end else if (state == IDLE) begin
         div_cnt <= '0;
         pix_en  <= 1'b0;
         if (en) state <= RUN;
      end else if (frame_wrap && !en) begin
         // en low on the wrapping edge ends the run here, whether RUN or STOPPING
         state       <= IDLE;
         div_cnt     <= '0;
         pix_en      <= 1'b0;
         hc          <= '0;
         vc          <= '0;
         frame_count <= frame_count + 32'd1;
         for (int i = 0; i <= PIPE_DLY; i++) pipe[i] <= VIDEO_RST;
      end else begin
         state <= en ? RUN : STOPPING;
         if (div_cnt == DW'(CLK_DIV - 1)) begin
            div_cnt <= '0;
            pix_en  <= 1'b1;
         end else begin
            div_cnt <= div_cnt + 1'b1;
            pix_en  <= 1'b0;
         end
         if (pix_en) begin
            hc <= h_last ? '0 : hc + 1'b1;
            if (h_last) vc <= v_last ? '0 : vc + 1'b1;
            if (frame_wrap) frame_count <= frame_count + 32'd1;
            pipe[0] <= dec;
            for (int i = 1; i <= PIPE_DLY; i++) pipe[i] <= pipe[i-1];
         end
      end
   end

   assign h_sync      = pipe[PIPE_DLY].h_sync;
   assign v_sync      = pipe[PIPE_DLY].v_sync;
   assign active      = pipe[PIPE_DLY].active;
   assign line_start  = pipe[PIPE_DLY].line_start;
   assign frame_start = pipe[PIPE_DLY].frame_start;
   assign pix_x       = pipe[PIPE_DLY].pix_x;
   assign pix_y       = pipe[PIPE_DLY].pix_y;
   assign running     = (state != IDLE);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a small raster: outputs are predicted from the strobe
// count since run start, decoded into raster position with plain arithmetic.
module tb_vga_timing_gen;

   localparam int D   = 3;
   localparam int HS  = 2, HB = 2, HA = 4, HF = 2;
   localparam int VS  = 1, VB = 1, VA = 3, VF = 1;
   localparam bit HP  = 1'b1;
   localparam bit VP  = 1'b0;
   localparam int PD  = 2;
   localparam int CW  = 8;
   localparam int HT  = HS + HB + HA + HF;
   localparam int VT  = VS + VB + VA + VF;
   localparam int TOT = HT * VT;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          en  = 1'b0;
   logic          pix_en, h_sync, v_sync, active, line_start, frame_start, running;
   logic [CW-1:0] pix_x, pix_y;
   logic [31:0]   frame_count;

   int vectors     = 0;
   int miscompares = 0;

   // reference model state
   logic        m_run = 1'b0;
   logic        m_pe  = 1'b0;
   int          k      = 0;
   int          nsteps = 0;
   logic [31:0] m_fc   = '0;

   typedef struct {
      logic hs, vs, act, ls, fs;
      int   px, py;
   } vid_t;

   vga_timing_gen #(
      .CLK_DIV(D), .H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA), .H_FP(HF),
      .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA), .V_FP(VF),
      .HS_POL(HP), .VS_POL(VP), .PIPE_DLY(PD), .CW(CW)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .pix_en(pix_en), .h_sync(h_sync), .v_sync(v_sync),
      .active(active), .line_start(line_start), .frame_start(frame_start),
      .pix_x(pix_x), .pix_y(pix_y), .frame_count(frame_count), .running(running)
   );

   initial forever #5 clk = ~clk;

   function automatic vid_t decode(input int pos);
      vid_t r;
      int h = pos % HT;
      int v = pos / HT;
      r.hs  = (h < HS) ? HP : ~HP;
      r.vs  = (v < VS) ? VP : ~VP;
      r.act = (h >= HS + HB) && (h < HS + HB + HA) && (v >= VS + VB) && (v < VS + VB + VA);
      r.px  = r.act ? h - (HS + HB) : 0;
      r.py  = r.act ? v - (VS + VB) : 0;
      r.ls  = r.act && (r.px == 0);
      r.fs  = r.ls && (r.py == 0);
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Strobe j (0-based) shows raster position j-PD; the run halts at a wrap seen with en low.
   task automatic model_edge(input logic e, input logic r);
      logic wrap;
      if (!r) begin
         m_run = 1'b0; m_pe = 1'b0; k = 0; nsteps = 0; m_fc = '0;
      end else if (!m_run) begin
         m_pe = 1'b0;
         if (e) begin m_run = 1'b1; k = 0; nsteps = 0; end
      end else begin
         wrap = m_pe && ((nsteps % TOT) == TOT - 1);
         if (m_pe) nsteps++;
         if (wrap) m_fc++;
         if (wrap && !e) begin
            m_run = 1'b0; m_pe = 1'b0; nsteps = 0;
         end else begin
            k++;
            m_pe = ((k % D) == 0);
         end
      end
   endtask

   task automatic check_all();
      vid_t x;
      if (m_run && nsteps > PD) x = decode((nsteps - 1 - PD) % TOT);
      else begin
         x.hs = ~HP; x.vs = ~VP; x.act = 1'b0; x.ls = 1'b0; x.fs = 1'b0; x.px = 0; x.py = 0;
      end
      check("pix_en",      32'(pix_en),      32'(m_pe));
      check("running",     32'(running),     32'(m_run));
      check("frame_count", frame_count,      m_fc);
      check("h_sync",      32'(h_sync),      32'(x.hs));
      check("v_sync",      32'(v_sync),      32'(x.vs));
      check("active",      32'(active),      32'(x.act));
      check("line_start",  32'(line_start),  32'(x.ls));
      check("frame_start", 32'(frame_start), 32'(x.fs));
      check("pix_x",       32'(pix_x),       x.px);
      check("pix_y",       32'(pix_y),       x.py);
   endtask

   task automatic cyc(input logic e, input logic r);
      en  = e;
      rst = r;
      @(posedge clk);
      model_edge(e, r);
      @(negedge clk);
      check_all();
   endtask

   initial begin
      // reset, then idle with en low
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b1);
      cyc(1'b0, 1'b1);
      // uninterrupted run over more than two frames
      repeat (450) cyc(1'b1, 1'b1);
      // drop en mid-frame: must finish the frame and stop
      for (int n = 0; n < 400 && running === 1'b1; n++) cyc(1'b0, 1'b1);
      check("stop_timeout", 32'(running), 32'd0);
      repeat (20) cyc(1'b0, 1'b1);
      // restart, then a short en dip inside a frame that must not disturb the raster
      repeat (100) cyc(1'b1, 1'b1);
      repeat (20) cyc(1'b0, 1'b1);
      repeat (200) cyc(1'b1, 1'b1);
      // reset in the middle of an active line
      for (int n = 0; n < 200 && active !== 1'b1; n++) cyc(1'b1, 1'b1);
      check("active_seen", 32'(active), 32'd1);
      cyc(1'b1, 1'b0);
      repeat (100) cyc(1'b1, 1'b1);
      // randomized run control with occasional resets
      repeat (3000) cyc($urandom_range(0, 9) < 7, $urandom_range(0, 299) != 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
